// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between the fetch port and the load/store port.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise data always beats fetch.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RET  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_lat_cnt;
  logic              r_owner;        // 1: outstanding read belongs to the data port
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              w_open;
  logic              w_d_win;
  logic              w_if_gnt;
  logic              w_d_gnt;
  logic              w_rd_gnt;
  logic              w_ret_cap;

  assign w_open = !reset && (r_state == IDLE || r_state == RD_RET);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last;                      // 1: data port received the most recent grant
  // On a tie the port that did not win last time is served.
  assign w_d_win = d_req && !(if_req && r_last);
`else
  assign w_d_win = d_req;
`endif

  assign w_d_gnt   = w_open && w_d_win;
  assign w_if_gnt  = w_open && !w_d_win && if_req;
  assign w_rd_gnt  = w_if_gnt || (w_d_gnt && !d_we);
  assign w_ret_cap = (r_state == RD_WAIT) && (r_lat_cnt == 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, RD_RET: w_next = w_rd_gnt ? RD_WAIT : IDLE;
      RD_WAIT:      if (r_lat_cnt == 2'd0) w_next = RD_RET;
      default:      w_next = IDLE;
    endcase
  end

  always_comb begin
    if_gnt    = w_if_gnt;
    d_gnt     = w_d_gnt;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (w_if_gnt) begin
      mem_en    = 1'b1;
      mem_be    = '1;
      mem_addr  = if_addr;
    end
    if_rvalid = (r_state == RD_RET) && !r_owner;
    d_rvalid  = (r_state == RD_RET) && r_owner;
    busy      = (r_state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lat_cnt  <= 2'd0;
      r_owner    <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_rd_gnt) begin
        r_lat_cnt <= LAT_INIT;
        r_owner   <= w_d_gnt;
      end else if (r_state == RD_WAIT && r_lat_cnt != 2'd0) begin
        r_lat_cnt <= r_lat_cnt - 2'd1;
      end
      if (w_ret_cap) begin
        if (r_owner) r_d_rdata  <= mem_rdata;
        else         r_if_rdata <= mem_rdata;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 1'b0;
    end else if (w_if_gnt) begin
      r_last <= 1'b0;
    end else if (w_d_gnt) begin
      r_last <= 1'b1;
    end
  end
`endif

  assign if_rdata = r_if_rdata;
  assign d_rdata  = r_d_rdata;

endmodule
